// File: rtl/ucode_sequencer.sv
// Microcode sequencer: walks the program ROM from a start address, decodes
// each 32-bit word and presents it to the datapath for its repeat count of
// beats. The program ends after the word that carries the last flag.
module ucode_sequencer #(
  parameter int ROM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROM_AW-1:0] start_addr,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_q,
  input  logic              stall,
  output logic              cmd_valid,
  output logic [6:0]        cmd_a,
  output logic [6:0]        cmd_b,
  output logic [10:0]       cmd_ctrl,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t            state;
  logic [ROM_AW-1:0] pc;
  logic [5:0]        rem;
  logic              last_r;
  logic [10:0]       ctrl_r;

  // A zero repeat count still issues the command once.
  function automatic logic [5:0] beats_of(input logic [5:0] cnt);
    beats_of = (cnt == 6'd0) ? 6'd1 : cnt;
  endfunction

  // Sequencer FSM: fetch, decode into the command registers, then issue beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= '0;
      rem    <= '0;
      last_r <= 1'b0;
      cmd_a  <= '0;
      cmd_b  <= '0;
      ctrl_r <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= start_addr;
            state <= FETCH;
          end
        end
        // ROM samples pc at the end of this cycle.
        FETCH: state <= LOAD;
        // rom_q now holds the word addressed in FETCH.
        LOAD: begin
          rem    <= beats_of(rom_q[31:26]);
          last_r <= rom_q[25];
          cmd_a  <= rom_q[24:18];
          cmd_b  <= rom_q[17:11];
          ctrl_r <= rom_q[10:0];
          state  <= ISSUE;
        end
        // A stalled beat holds everything; an accepted one counts down.
        ISSUE: begin
          if (!stall) begin
            rem <= rem - 6'd1;
            if (rem == 6'd1) begin
              if (last_r) begin
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                // Address wraps at the top of the ROM.
                pc    <= pc + {{(ROM_AW-1){1'b0}}, 1'b1};
                state <= FETCH;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rom_addr  = pc;
  assign cmd_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign cmd_ctrl  = cmd_valid ? ctrl_r : 11'd0;

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Microcode sequencer for the pairing core. It walks the program ROM from a given start address and decodes each 32-bit word. Each decoded command is presented to the datapath for the number of beats given in the word's repeat field, and the program ends at the word carrying the last flag. It sits between the top-level control (start/done) and the `rom` instance plus the datapath register file and ALU.

## Interface

Parameters:
- `ROM_AW`, default 10: ROM address width; the word format is fixed at 32 bits.

Ports:
- `clk`, input, 1: the single clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: program launch request; sampled only in IDLE.
- `start_addr`, input, ROM_AW: address of the first program word; captured on the accepted `start`.
- `rom_addr`, output, ROM_AW: address driven to the synchronous ROM.
- `rom_q`, input, 32: ROM data, valid the cycle after `rom_addr` is sampled.
- `stall`, input, 1: datapath not accepting; a beat is consumed only when `cmd_valid & ~stall`.
- `cmd_valid`, output, 1: command beat presented.
- `cmd_a`, output, 7: operand/write address A, from word bits [24:18].
- `cmd_b`, output, 7: operand address B, from word bits [17:11].
- `cmd_ctrl`, output, 11: datapath control/load enables, from bits [10:0]; forced 0 whenever `cmd_valid`=0.
- `busy`, output, 1: high whenever the state is not IDLE.
- `done`, output, 1: one-cycle pulse after the last beat of a program.

## Operation

Word format:
- [31:26] repeat count `cnt`.
- [25] last flag.
- [24:18] A.
- [17:11] B.
- [10:0] ctrl.

Registers:
- `pc` (ROM_AW bits); `rom_addr` = `pc`.
- `rem` (6-bit remaining beats).
- `last_r`.
- `cmd_a`, `cmd_b`, `ctrl_r`.

FSM has four states, IDLE, FETCH, LOAD and ISSUE:
- IDLE:
  - On `start`=1: `pc` <= `start_addr`, go to FETCH. Otherwise stay.
  - `start` in any other state is ignored.
- FETCH: ROM samples `pc` at the end of this cycle. Go to LOAD.
- LOAD: on the cycle's end edge, latch the fields of `rom_q`:
  - `rem` <= (`cnt`==0 ? 1 : `cnt`); a zero count means one beat.
  - `last_r` <= bit 25.
  - A/B/ctrl into their registers.
  - Go to ISSUE.
- ISSUE:
  - `cmd_valid`=1 and `cmd_ctrl`=`ctrl_r`.
  - On an accepted beat (`~stall`), `rem` decrements.
  - When the accepted beat has `rem`==1:
    - If `last_r`=1: go to IDLE and set `done` for the next cycle.
    - Otherwise: `pc` <= `pc`+1 (mod 2^ROM_AW, wraps 1023→0 by design) and go to FETCH.
  - While `stall`=1: hold all state; A/B/ctrl stay stable and `cmd_valid` stays high.
- `cmd_a`/`cmd_b` hold their last value when not valid. `cmd_ctrl` reads 0 when not valid.
- The sequencer has no other termination: a program without a last flag runs forever, wrapping the address.

Reset:
- Async `reset` in any state forces IDLE immediately.
- `pc`, `rem`, `last_r`, A, B, `ctrl_r` and `done` clear to 0.
- Outputs at reset: `rom_addr`=0, `cmd_valid`=0, `cmd_a`=0, `cmd_b`=0, `cmd_ctrl`=0, `busy`=0, `done`=0.
- A reset mid-program abandons it with no `done` pulse.

## Timing

Notation: edge 0 is the edge that samples `start`.
- First command:
  - Cycle 1 is FETCH and cycle 2 is LOAD.
  - The first `cmd_valid` is in cycle 3: start-to-first-beat latency is 3 cycles.
- A word with count N and no stalls is valid for N consecutive cycles.
- Between consecutive words there are 2 bubble cycles (FETCH, LOAD) with `cmd_valid`=0.
- After the final accepted beat in cycle k:
  - Cycle k+1 has `done`=1 and `busy`=0.
  - A `start` in cycle k+1 is accepted.
- `busy` is 1 from cycle 1 through the final beat's cycle.
- Stall: each stalled cycle extends ISSUE by exactly one cycle. No beat is lost or duplicated.

## Test plan

- **Reference program.** ROM words:
  - 1 = {1,0,0,2,0}
  - 2 = {2,0,4,2,0x600}
  - 3 = {1,1,3,0,0x1D1}

  Stimulus: start with `start_addr`=1. Required response:
  - Cycle 3: valid with A=0, B=2, ctrl=0.
  - Cycles 6–7: valid with A=4, B=2, ctrl=0x600.
  - Cycle 10: valid with A=3, B=0, ctrl=0x1D1.
  - Cycle 11: `done`=1, `busy`=0.
  - Nothing else is valid.
- **Stall.** Same program, with `stall`=1 in cycles 6–8:
  - The A=4 beats are accepted in cycles 9 and 10.
  - The last word is valid in cycle 13.
  - `done` pulses in cycle 14.
- **Zero count.** Word 5 = {0,1,7,9,0x3}, start at 5:
  - Exactly one beat, in cycle 3, with ctrl=0x3.
  - `done` in cycle 4.
- **Wrap.** `start_addr`=1023, word 1023 has last=0 and cnt=1; word 0 has last=1:
  - `rom_addr` goes 1023 → 0.
  - Two beats are issued, then `done`.
- **Reset mid-run.** Assert `reset` during cycle 6 of the reference program:
  - `cmd_valid`, `busy` and `rom_addr` go to 0 asynchronously.
  - No `done`.
  - After release, `start` with `start_addr`=1 reproduces the reference-program trace.
- **Start while busy.** A `start` pulse with `start_addr`=5 in cycle 4 of the reference program is ignored; the trace is unchanged.
